throw_scheduler: RTL and testbench

Sequences a validated siteswap pattern into per-beat throw commands. It sits downstream of the pattern-entry/validation block and consumes its registered pattern, length, ball count and valid flag. On every beat it decides which ball is in hand, which hand throws it and how high, and it tracks every airborne ball's landing beat in an 8-entry circular landing ring. Its outputs drive the animation/render side of the design.

---
 rtl/throw_scheduler.sv | 148 ++++++++++++++
 tb/tb_throw_scheduler.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/throw_scheduler.sv
// Siteswap throw sequencer: walks a latched pattern beat by beat, assigns balls to throws
// and tracks airborne balls in a circular landing ring indexed by landing beat.
module throw_scheduler #(
   parameter int MAX_LEN = 7,
   parameter int RING    = 8
) (
   input  logic                   clk_in,
   input  logic                   rst_n_in,
   input  logic                   new_beat,
   input  logic [3*MAX_LEN-1:0]   pattern_in,
   input  logic [2:0]             pattern_length,
   input  logic [2:0]             num_balls_in,
   input  logic                   pattern_valid_in,
   output logic                   throw_valid_out,
   output logic [2:0]             ball_id_out,
   output logic [2:0]             throw_height_out,
   output logic                   hand_out,
   output logic                   beat_done_out,
   output logic [2:0]             beat_index_out,
   output logic                   running_out,
   output logic                   error_out
);

   localparam int AW = $clog2(RING);

   typedef enum logic [1:0] {IDLE, LOAD, RUN, ERROR} state_t;

   state_t          state_q, state_d;
   logic [2:0]      pattern_q [8];
   logic [2:0]      len_q, balls_q, idx_q, intro_q;
   logic            hand_q;
   logic [AW-1:0]   head_q;
   logic            ring_valid [RING];
   logic [2:0]      ring_ball  [RING];

   logic [2:0]      h, ball;
   logic [AW-1:0]   target;
   logic            slot_valid, beat, fire, new_ball, fault, advance;

   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) state_q <= IDLE;
      else           state_q <= state_d;
   end

   // NOTE: every variable gets a default before the case, so no path can infer a latch.
   always_comb begin
      state_d    = state_q;
      beat       = 1'b0;
      fire       = 1'b0;
      new_ball   = 1'b0;
      fault      = 1'b0;
      h          = pattern_q[idx_q];
      slot_valid = ring_valid[head_q];
      ball       = ring_ball[head_q];
      target     = head_q + AW'(h);
      case (state_q)
         IDLE:  if (pattern_valid_in) state_d = LOAD;
         LOAD:  state_d = RUN;
         RUN: begin
            if (!pattern_valid_in) begin
               state_d = IDLE;
            end else if (new_beat) begin
               beat = 1'b1;
               if (slot_valid) begin
                  fire  = (h != 3'd0);
                  fault = (h == 3'd0);
               end else if (h != 3'd0) begin
                  if (intro_q < balls_q) begin
                     fire     = 1'b1;
                     new_ball = 1'b1;
                     ball     = intro_q;
                  end else begin
                     fault = 1'b1;
                  end
               end
               // A throw landing on an occupied beat is a collision as well.
               if (fire && ring_valid[target]) fault = 1'b1;
               if (fault) state_d = ERROR;
            end
         end
         ERROR: if (!pattern_valid_in) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   assign advance = beat && !fault;

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         for (int i = 0; i < 8; i++) pattern_q[i] <= 3'd0;
         for (int i = 0; i < RING; i++) ring_valid[i] <= 1'b0;
         len_q   <= 3'd0;
         balls_q <= 3'd0;
         idx_q   <= 3'd0;
         intro_q <= 3'd0;
         hand_q  <= 1'b0;
         head_q  <= '0;
      end else if (state_q == LOAD) begin
         for (int i = 0; i < MAX_LEN; i++) pattern_q[i] <= pattern_in[3*i +: 3];
         for (int i = 0; i < RING; i++) ring_valid[i] <= 1'b0;
         len_q   <= pattern_length;
         balls_q <= num_balls_in;
         idx_q   <= 3'd0;
         intro_q <= 3'd0;
         hand_q  <= 1'b0;
         head_q  <= '0;
      end else if (advance) begin
         ring_valid[head_q] <= 1'b0;
         if (fire) ring_valid[target] <= 1'b1;
         head_q  <= head_q + 1'b1;
         idx_q   <= (idx_q == len_q - 3'd1) ? 3'd0 : idx_q + 3'd1;
         hand_q  <= ~hand_q;
         if (new_ball) intro_q <= intro_q + 3'd1;
      end
   end

   // NOTE: ball IDs are only read behind their valid bit, so this storage needs no reset.
   always_ff @(posedge clk_in) begin
      if (advance && fire) ring_ball[target] <= ball;
   end

   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in || state_d != RUN) begin
         throw_valid_out  <= 1'b0;
         ball_id_out      <= 3'd0;
         throw_height_out <= 3'd0;
         hand_out         <= 1'b0;
         beat_done_out    <= 1'b0;
         beat_index_out   <= 3'd0;
      end else begin
         throw_valid_out <= 1'b0;
         beat_done_out   <= 1'b0;
         if (advance) begin
            throw_valid_out  <= fire;
            beat_done_out    <= 1'b1;
            if (fire) ball_id_out <= ball;
            throw_height_out <= h;
            hand_out         <= hand_q;
            beat_index_out   <= idx_q;
         end
      end
   end

   assign running_out = (state_q == RUN);
   assign error_out   = (state_q == ERROR);

endmodule

// File: tb/tb_throw_scheduler.sv
// Bench for throw_scheduler: expected beats are queued as stimulus is driven and
// compared by a monitor whenever the scheduler reports a processed beat.
module tb_throw_scheduler;

   localparam int MAX_LEN = 7;

   logic                 clk_in = 1'b0;
   logic                 rst_n_in = 1'b1;
   logic                 new_beat = 1'b0;
   logic [3*MAX_LEN-1:0] pattern_in = '0;
   logic [2:0]           pattern_length = 3'd1;
   logic [2:0]           num_balls_in = 3'd1;
   logic                 pattern_valid_in = 1'b0;
   logic                 throw_valid_out, hand_out, beat_done_out, running_out, error_out;
   logic [2:0]           ball_id_out, throw_height_out, beat_index_out;

   typedef struct packed {
      logic       thr;
      logic [2:0] id;
      logic [2:0] height;
      logic       hand;
      logic [2:0] idx;
   } beat_t;

   beat_t exp_q[$];
   beat_t mon_exp, mon_got;
   int    checks = 0;
   int    errors = 0;
   int    beat_no = 0;

   logic [13:0] all_out;
   logic [12:0] all_but_err;
   assign all_out     = {throw_valid_out, ball_id_out, throw_height_out, hand_out,
                         beat_done_out, beat_index_out, running_out, error_out};
   assign all_but_err = all_out[13:1];

   throw_scheduler #(.MAX_LEN(MAX_LEN), .RING(8)) dut (
      .clk_in(clk_in), .rst_n_in(rst_n_in), .new_beat(new_beat),
      .pattern_in(pattern_in), .pattern_length(pattern_length),
      .num_balls_in(num_balls_in), .pattern_valid_in(pattern_valid_in),
      .throw_valid_out(throw_valid_out), .ball_id_out(ball_id_out),
      .throw_height_out(throw_height_out), .hand_out(hand_out),
      .beat_done_out(beat_done_out), .beat_index_out(beat_index_out),
      .running_out(running_out), .error_out(error_out)
   );

   always #5 clk_in = ~clk_in;

   // Scoreboard monitor: every reported beat must match the oldest queued expectation.
   always @(negedge clk_in) begin
      if (beat_done_out) begin
         checks++;
         beat_no++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_beat: beat_done_out=1 idx=%0d thr=%0b, expected no beat",
                     beat_index_out, throw_valid_out);
         end else begin
            mon_exp = exp_q.pop_front();
            mon_got = '{thr: throw_valid_out, id: ball_id_out, height: throw_height_out,
                        hand: hand_out, idx: beat_index_out};
            if (!mon_exp.thr) mon_got.id = mon_exp.id;
            if (mon_got !== mon_exp) begin
               errors++;
               $display("FAIL beat_%0d: got thr=%0b id=%0d h=%0d hand=%0b idx=%0d, expected thr=%0b id=%0d h=%0d hand=%0b idx=%0d",
                        beat_no, mon_got.thr, mon_got.id, mon_got.height, mon_got.hand, mon_got.idx,
                        mon_exp.thr, mon_exp.id, mon_exp.height, mon_exp.hand, mon_exp.idx);
            end
         end
      end
   end

   task automatic push_beat(input logic thr, input logic [2:0] id, input logic [2:0] height,
                            input logic hand, input logic [2:0] idx);
      exp_q.push_back('{thr: thr, id: id, height: height, hand: hand, idx: idx});
   endtask

   task automatic beat_pulse();
      @(negedge clk_in);
      new_beat = 1'b1;
      @(negedge clk_in);
      new_beat = 1'b0;
   endtask

   task automatic load_pattern(input logic [3*MAX_LEN-1:0] p, input logic [2:0] len,
                               input logic [2:0] balls);
      @(negedge clk_in);
      pattern_in       = p;
      pattern_length   = len;
      num_balls_in     = balls;
      pattern_valid_in = 1'b1;
      repeat (2) @(negedge clk_in);
   endtask

   task automatic stop_pattern();
      @(negedge clk_in);
      pattern_valid_in = 1'b0;
      @(negedge clk_in);
   endtask

   task automatic test_reset();
      #1 rst_n_in = 1'b0;
      pattern_valid_in = 1'b0;
      repeat (3) @(negedge clk_in);
      checks++;
      if (all_out !== 14'd0) begin
         errors++;
         $display("FAIL reset_outputs: got %b, expected all zero", all_out);
      end
      rst_n_in = 1'b1;
      repeat (2) @(negedge clk_in);
   endtask

   task automatic test_pattern_3();
      @(negedge clk_in);
      pattern_in       = {18'd0, 3'd3};
      pattern_length   = 3'd1;
      num_balls_in     = 3'd3;
      pattern_valid_in = 1'b1;
      new_beat         = 1'b1;
      @(negedge clk_in);
      checks++;
      if (running_out !== 1'b0) begin
         errors++;
         $display("FAIL running_in_load: got %b, expected 0", running_out);
      end
      @(negedge clk_in);
      new_beat = 1'b0;
      checks++;
      if (running_out !== 1'b1) begin
         errors++;
         $display("FAIL running_in_run: got %b, expected 1", running_out);
      end
      for (int i = 0; i < 6; i++) begin
         push_beat(1'b1, 3'(i % 3), 3'd3, 1'(i % 2), 3'd0);
         beat_pulse();
      end
      repeat (3) @(negedge clk_in);
      checks++;
      if (exp_q.size() != 0 || error_out !== 1'b0) begin
         errors++;
         $display("FAIL pattern3_drain: got %0d pending, error_out=%b, expected 0 pending, 0", exp_q.size(), error_out);
         exp_q.delete();
      end
      stop_pattern();
      checks++;
      if (running_out !== 1'b0) begin
         errors++;
         $display("FAIL stop_running: got %b, expected 0", running_out);
      end
   endtask

   task automatic test_back_to_back_441();
      logic [2:0] ids [8];
      logic [2:0] hts [8];
      ids = '{3'd0, 3'd1, 3'd2, 3'd2, 3'd0, 3'd1, 3'd1, 3'd2};
      hts = '{3'd4, 3'd4, 3'd1, 3'd4, 3'd4, 3'd1, 3'd4, 3'd4};
      load_pattern({12'd0, 3'd1, 3'd4, 3'd4}, 3'd3, 3'd3);
      for (int i = 0; i < 8; i++) push_beat(1'b1, ids[i], hts[i], 1'(i % 2), 3'(i % 3));
      new_beat = 1'b1;
      repeat (8) @(negedge clk_in);
      new_beat = 1'b0;
      repeat (3) @(negedge clk_in);
      checks++;
      if (exp_q.size() != 0 || error_out !== 1'b0) begin
         errors++;
         $display("FAIL p441_drain: got %0d pending, error_out=%b, expected 0 pending, 0", exp_q.size(), error_out);
         exp_q.delete();
      end
      stop_pattern();
   endtask

   task automatic test_empty_beats_40();
      load_pattern({15'd0, 3'd0, 3'd4}, 3'd2, 3'd2);
      push_beat(1'b1, 3'd0, 3'd4, 1'b0, 3'd0);
      push_beat(1'b0, 3'd0, 3'd0, 1'b1, 3'd1);
      push_beat(1'b1, 3'd1, 3'd4, 1'b0, 3'd0);
      push_beat(1'b0, 3'd0, 3'd0, 1'b1, 3'd1);
      push_beat(1'b1, 3'd0, 3'd4, 1'b0, 3'd0);
      for (int i = 0; i < 5; i++) beat_pulse();
      repeat (3) @(negedge clk_in);
      checks++;
      if (exp_q.size() != 0 || error_out !== 1'b0) begin
         errors++;
         $display("FAIL p40_drain: got %0d pending, error_out=%b, expected 0 pending, 0", exp_q.size(), error_out);
         exp_q.delete();
      end
   endtask

   task automatic test_drop_reload();
      // Drop the pattern with a beat in the same cycle; that beat must be lost.
      @(negedge clk_in);
      pattern_valid_in = 1'b0;
      new_beat         = 1'b1;
      @(negedge clk_in);
      new_beat = 1'b0;
      checks++;
      if (running_out !== 1'b0) begin
         errors++;
         $display("FAIL drop_running: got %b, expected 0", running_out);
      end
      load_pattern({18'd0, 3'd5}, 3'd1, 3'd5);
      for (int i = 0; i < 6; i++) begin
         push_beat(1'b1, 3'(i % 5), 3'd5, 1'(i % 2), 3'd0);
         beat_pulse();
      end
      repeat (3) @(negedge clk_in);
      checks++;
      if (exp_q.size() != 0 || error_out !== 1'b0) begin
         errors++;
         $display("FAIL reload_drain: got %0d pending, error_out=%b, expected 0 pending, 0", exp_q.size(), error_out);
         exp_q.delete();
      end
      stop_pattern();
   endtask

   task automatic test_error_12();
      load_pattern({15'd0, 3'd2, 3'd1}, 3'd2, 3'd1);
      push_beat(1'b1, 3'd0, 3'd1, 1'b0, 3'd0);
      push_beat(1'b1, 3'd0, 3'd2, 1'b1, 3'd1);
      beat_pulse();
      beat_pulse();
      beat_pulse();
      checks++;
      if (error_out !== 1'b1 || all_but_err !== 13'd0) begin
         errors++;
         $display("FAIL starvation_error: got error=%b others=%b, expected error=1 others=0", error_out, all_but_err);
      end
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL error_drain: got %0d pending, expected 0", exp_q.size());
         exp_q.delete();
      end
      beat_pulse();
      repeat (3) @(negedge clk_in);
      checks++;
      if (error_out !== 1'b1) begin
         errors++;
         $display("FAIL error_sticky: got %b, expected 1", error_out);
      end
      stop_pattern();
      checks++;
      if (error_out !== 1'b0) begin
         errors++;
         $display("FAIL error_clear: got %b, expected 0", error_out);
      end
   endtask

   task automatic test_reset_mid_run();
      load_pattern({18'd0, 3'd5}, 3'd1, 3'd5);
      for (int i = 0; i < 3; i++) begin
         push_beat(1'b1, 3'(i), 3'd5, 1'(i % 2), 3'd0);
         beat_pulse();
      end
      @(negedge clk_in);
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL premid_drain: got %0d pending, expected 0", exp_q.size());
         exp_q.delete();
      end
      #2 rst_n_in = 1'b0;
      pattern_valid_in = 1'b0;
      #1;
      checks++;
      if (all_out !== 14'd0) begin
         errors++;
         $display("FAIL async_reset: got %b, expected all zero", all_out);
      end
      @(negedge clk_in);
      rst_n_in = 1'b1;
      beat_pulse();
      beat_pulse();
      checks++;
      if (running_out !== 1'b0) begin
         errors++;
         $display("FAIL idle_after_reset: got running=%b, expected 0", running_out);
      end
      load_pattern({18'd0, 3'd3}, 3'd1, 3'd3);
      push_beat(1'b1, 3'd0, 3'd3, 1'b0, 3'd0);
      beat_pulse();
      repeat (2) @(negedge clk_in);
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL post_reset_drain: got %0d pending, expected 0", exp_q.size());
         exp_q.delete();
      end
      stop_pattern();
   endtask

   initial begin
      test_reset();
      test_pattern_3();
      test_back_to_back_441();
      test_empty_beats_40();
      test_drop_reload();
      test_error_12();
      test_reset_mid_run();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog expired");
   end

endmodule
